// File: rtl/imem_pkg.sv
// Shared definitions for the boot-time instruction-memory loader and the
// instruction memory it feeds.
package imem_pkg;

   localparam int IMEM_ADDR_W    = 14;
   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      DATA = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } loader_state_e;

   // A header is usable when it names at least one word and no more than the memory holds.
   function automatic logic hdr_count_ok(input logic [15:0] count, input int unsigned addr_w);
      logic [31:0] depth;
      depth = 32'd1 << addr_w;
      return (count != 16'd0) && ({16'd0, count} <= depth);
   endfunction

   function automatic logic [31:0] hdr_last_index(input logic [15:0] count);
      return {16'd0, count} - 32'd1;
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: 16-bit word-count header, then little-endian
// 32-bit words written to consecutive instruction-memory addresses from 0.
import imem_pkg::*;

module imem_loader #(
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              rx_valid_i,
   input  logic [7:0]        rx_data_i,
   output logic              rx_ready_o,
   output logic              mem_wen_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   output logic              core_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   loader_state_e     state_r;
   loader_state_e     state_s;

   logic              hdr_idx_r;
   logic [7:0]        cnt_lo_r;
   logic [ADDR_W-1:0] last_idx_r;
   logic [ADDR_W-1:0] word_idx_r;
   logic [1:0]        byte_idx_r;
   logic [23:0]       hold_r;

   logic              rx_ready_r;
   logic              mem_wen_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [31:0]       mem_data_r;
   logic              core_rst_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;

   logic              accept_s;
   logic              restart_s;
   logic              word_last_s;
   logic [15:0]       count_s;
   logic              ready_s;
   logic              core_rst_s;

   // The registered ready flag tracks the state, so acceptance never waits on a combinational path.
   assign accept_s    = rx_valid_i & rx_ready_r;
   assign restart_s   = start_i & ((state_r == IDLE) | (state_r == DONE) | (state_r == ERR));
   assign word_last_s = accept_s & (state_r == DATA) & (byte_idx_r == 2'd3);
   assign count_s     = {rx_data_i, cnt_lo_r};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE, DONE, ERR: begin
            if (start_i) begin
               state_s = HDR;
            end else begin
               state_s = state_r;
            end
         end
         HDR: begin
            if (accept_s && hdr_idx_r) begin
               if (hdr_count_ok(count_s, ADDR_W)) begin
                  state_s = DATA;
               end else begin
                  state_s = ERR;
               end
            end else begin
               state_s = HDR;
            end
         end
         DATA: begin
            if (word_last_s && (word_idx_r == last_idx_r)) begin
               state_s = DONE;
            end else begin
               state_s = DATA;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Header capture, byte packer and word index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hdr_idx_r  <= 1'b0;
         cnt_lo_r   <= 8'd0;
         last_idx_r <= '0;
         word_idx_r <= '0;
         byte_idx_r <= 2'd0;
         hold_r     <= 24'd0;
      end else begin
         case (state_r)
            IDLE, DONE, ERR: begin
               if (restart_s) begin
                  hdr_idx_r  <= 1'b0;
                  word_idx_r <= '0;
                  byte_idx_r <= 2'd0;
               end
            end
            HDR: begin
               if (accept_s) begin
                  if (!hdr_idx_r) begin
                     cnt_lo_r  <= rx_data_i;
                     hdr_idx_r <= 1'b1;
                  end else begin
                     hdr_idx_r  <= 1'b0;
                     last_idx_r <= ADDR_W'(hdr_last_index(count_s));
                     word_idx_r <= '0;
                     byte_idx_r <= 2'd0;
                  end
               end
            end
            DATA: begin
               if (accept_s) begin
                  case (byte_idx_r)
                     2'd0:    hold_r[7:0]   <= rx_data_i;
                     2'd1:    hold_r[15:8]  <= rx_data_i;
                     2'd2:    hold_r[23:16] <= rx_data_i;
                     default: hold_r        <= hold_r;
                  endcase
                  byte_idx_r <= byte_idx_r + 2'd1;
                  if (byte_idx_r == 2'd3) begin
                     word_idx_r <= word_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            default: begin
               hdr_idx_r <= 1'b0;
            end
         endcase
      end
   end

   // Write port: address/data hold between writes, strobe lasts one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wen_r  <= 1'b0;
         mem_addr_r <= '0;
         mem_data_r <= 32'd0;
      end else begin
         mem_wen_r <= word_last_s;
         if (word_last_s) begin
            mem_addr_r <= word_idx_r;
            mem_data_r <= {rx_data_i, hold_r};
         end
      end
   end

   // Status decode from the next state; core release waits one cycle in DONE
   always_comb begin
      ready_s    = 1'b0;
      core_rst_s = 1'b1;
      if ((state_s == HDR) || (state_s == DATA)) begin
         ready_s = 1'b1;
      end else begin
         ready_s = 1'b0;
      end
      if ((state_r == DONE) && (state_s == DONE)) begin
         core_rst_s = 1'b0;
      end else begin
         core_rst_s = 1'b1;
      end
   end

   // Registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ready_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         core_rst_r <= 1'b1;
      end else begin
         rx_ready_r <= ready_s;
         busy_r     <= ready_s;
         done_r     <= (state_s == DONE);
         err_r      <= (state_s == ERR);
         core_rst_r <= core_rst_s;
      end
   end

   assign rx_ready_o = rx_ready_r;
   assign mem_wen_o  = mem_wen_r;
   assign mem_addr_o = mem_addr_r;
   assign mem_data_o = mem_data_r;
   assign core_rst_o = core_rst_r;
   assign busy_o     = busy_r;
   assign done_o     = done_r;
   assign err_o      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and checked by an independent monitor on every write strobe.
module tb_imem_loader;
   import imem_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic        mem_wen_o;
   logic [13:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        core_rst_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  ntests = 0;
   int  nfail  = 0;

   imem_loader #(.ADDR_W(14)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .rx_valid_i (rx_valid_i),
      .rx_data_i  (rx_data_i),
      .rx_ready_o (rx_ready_o),
      .mem_wen_o  (mem_wen_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_o (mem_data_o),
      .core_rst_o (core_rst_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (mem_wen_o !== 1'b0) begin
         if (exp_q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_wen: got write addr 0x%0h data 0x%0h expected none",
                     mem_addr_o, mem_data_o);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr_o), 32'(e.addr));
            chk("wr_data", mem_data_o, e.data);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push_wr(input logic [13:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Offers one byte after gap idle cycles; returns at posedge+1 of the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      rx_valid_i = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      rx_valid_i = 1'b1;
      rx_data_i  = b;
      n = 0;
      @(negedge clk);
      while (!rx_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready_o) begin
         ntests++;
         nfail++;
         $display("FAIL byte_timeout: got rx_ready_o=0 expected 1 for byte 0x%0h", b);
         rx_valid_i = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         rx_valid_i = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[7:0], gap);
      send_byte(w[15:8], gap);
      send_byte(w[23:16], gap);
      send_byte(w[31:24], gap);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic two_word_image(input int gap);
      push_wr(14'd0, 32'h01100F13);
      push_wr(14'd1, 32'h00500093);
      send_byte(8'h02, gap);
      send_byte(8'h00, gap);
      send_word(32'h01100F13, gap);
      send_word(32'h00500093, gap);
      chk("last_wen", 32'(mem_wen_o), 32'd1);
      chk("last_addr", 32'(mem_addr_o), 32'd1);
      chk("done_with_last", 32'(done_o), 32'd1);
      chk("ready_in_done", 32'(rx_ready_o), 32'd0);
      chk("core_rst_at_last", 32'(core_rst_o), 32'd1);
      @(posedge clk);
      #1;
      chk("core_release", 32'(core_rst_o), 32'd0);
      chk("wen_one_cycle", 32'(mem_wen_o), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      start_i    = 1'b0;
      rx_valid_i = 1'b0;
      rx_data_i  = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(rx_ready_o), 32'd0);
      chk("rst_wen", 32'(mem_wen_o), 32'd0);
      chk("rst_addr", 32'(mem_addr_o), 32'd0);
      chk("rst_data", mem_data_o, 32'd0);
      chk("rst_core_rst", 32'(core_rst_o), 32'd1);
      chk("rst_flags", {29'd0, busy_o, done_o, err_o}, 32'd0);

      // Idle with a byte on offer: nothing consumed, nothing written
      rst        = 1'b0;
      rx_valid_i = 1'b1;
      rx_data_i  = 8'hAA;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("idle_ready", 32'(rx_ready_o), 32'd0);
      chk("idle_core_rst", 32'(core_rst_o), 32'd1);
      chk("idle_flags", {29'd0, busy_o, done_o, err_o}, 32'd0);
      rx_valid_i = 1'b0;

      // Back-to-back two-word image
      pulse_start();
      chk("start_busy", 32'(busy_o), 32'd1);
      two_word_image(0);

      // Restart from DONE, then the same image with 3-cycle gaps
      pulse_start();
      chk("done_restart_core_rst", 32'(core_rst_o), 32'd1);
      chk("done_restart_busy", 32'(busy_o), 32'd1);
      chk("done_restart_done", 32'(done_o), 32'd0);
      two_word_image(3);

      // Zero-count header
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("hdr0_err", 32'(err_o), 32'd1);
      chk("hdr0_busy", 32'(busy_o), 32'd0);
      chk("hdr0_core_rst", 32'(core_rst_o), 32'd1);
      rx_valid_i = 1'b1;
      rx_data_i  = 8'h55;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      rx_valid_i = 1'b0;
      chk("err_ready", 32'(rx_ready_o), 32'd0);
      chk("err_sticky", 32'(err_o), 32'd1);

      // Oversize header 0x4001
      pulse_start();
      chk("err_restart_clear", 32'(err_o), 32'd0);
      send_byte(8'h01, 0);
      send_byte(8'h40, 0);
      chk("hdr4001_err", 32'(err_o), 32'd1);

      // Reset in the middle of word 0, then a fresh one-word image
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h0F, 0);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_ready", 32'(rx_ready_o), 32'd0);
      chk("midrst_wen", 32'(mem_wen_o), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      pulse_start();
      push_wr(14'd0, 32'hDEADBEEF);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_word(32'hDEADBEEF, 0);
      chk("fresh_done", 32'(done_o), 32'd1);
      chk("fresh_data", mem_data_o, 32'hDEADBEEF);

      // start_i during DATA is ignored
      pulse_start();
      push_wr(14'd0, 32'hCAFEF00D);
      push_wr(14'd1, 32'h12345678);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h0D, 0);
      send_byte(8'hF0, 0);
      pulse_start();
      chk("start_in_data_busy", 32'(busy_o), 32'd1);
      send_byte(8'hFE, 0);
      send_byte(8'hCA, 0);
      send_byte(8'h78, 0);
      pulse_start();
      send_byte(8'h56, 0);
      send_byte(8'h34, 0);
      send_byte(8'h12, 0);
      chk("start_in_data_done", 32'(done_o), 32'd1);
      chk("start_in_data_addr", 32'(mem_addr_o), 32'd1);

      // Full-depth image: header 0x4000
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h40, 0);
      chk("hdr4000_err", 32'(err_o), 32'd0);
      chk("hdr4000_busy", 32'(busy_o), 32'd1);
      for (int i = 0; i < 16384; i++) begin
         logic [31:0] w;
         w = 32'hC3000000 | 32'(i);
         push_wr(14'(i), w);
         send_word(w, 0);
      end
      chk("full_done", 32'(done_o), 32'd1);
      chk("full_last_addr", 32'(mem_addr_o), 32'h3FFF);
      @(posedge clk);
      #1;
      chk("full_core_release", 32'(core_rst_o), 32'd0);
      chk("full_queue_drained", 32'(exp_q.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the instruction memory's write port. It accepts a byte stream (typically from a UART receiver) carrying a 16-bit word-count header followed by little-endian 32-bit instruction words. It writes each word to consecutive instruction-memory addresses starting at 0. It holds the core in reset until the whole image has been written.

## Interface
Parameters:
- ADDR_W, 14, instruction-memory word-address width; memory depth = 2**ADDR_W words.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start_i  in  1  single-cycle pulse that begins a new load.
- rx_valid_i  in  1  byte available on rx_data_i.
- rx_data_i  in  8  incoming byte.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- mem_wen_o  out  1  write strobe to instruction memory.
- mem_addr_o  out  ADDR_W  word address for the write.
- mem_data_o  out  32  word to write.
- core_rst_o  out  1  hold-in-reset for the core; high until the load completes.
- busy_o  out  1  load in progress.
- done_o  out  1  image fully written.
- err_o  out  1  header rejected.

## Operation
- States: IDLE, HDR, DATA, DONE, ERR. Reset puts the FSM in IDLE.
- A byte is consumed only on rx_valid_i && rx_ready_o.
- rx_ready_o = 1 in HDR and DATA, 0 otherwise. Bytes offered in other states are not consumed.
- start_i:
  - In IDLE, DONE or ERR: go to HDR, clear the byte and word counters, clear done_o/err_o.
  - In HDR or DATA: ignored.
- HDR:
  - First byte = count[7:0], second byte = count[15:8].
  - After the second byte: if count == 0 or count > 2**ADDR_W, go to ERR. Otherwise go to DATA with word index 0 and byte index 0.
- DATA:
  - Bytes are packed little-endian: byte 0 goes to [7:0], byte 3 goes to [31:24].
  - On acceptance of byte 3, the assembled word and the current word index are registered into mem_data_o/mem_addr_o.
  - mem_wen_o pulses high for exactly one cycle, in the cycle after byte 3 is accepted.
  - The word index then increments and the byte index wraps to 0.
  - If that was word count-1, the FSM enters DONE in the same cycle as the write pulse.
- DONE: done_o = 1, core_rst_o = 0.
- ERR: err_o = 1, core_rst_o stays 1, no writes. Leaves ERR only on start_i or rst.
- busy_o = 1 in HDR and DATA.
- rst at any time: FSM returns to IDLE, the partial word is discarded, and no further mem_wen_o is issued. Words already written remain in memory.

## Timing
- Reset values: rx_ready_o=0, mem_wen_o=0, mem_addr_o=0, mem_data_o=0, core_rst_o=1, busy_o=0, done_o=0, err_o=0.
- All outputs are registered; none depend combinationally on rx_valid_i or rx_data_i.
- Write latency: mem_wen_o is high exactly 1 cycle after the 4th byte of a word is accepted.
- mem_addr_o/mem_data_o are valid while mem_wen_o=1 and hold their values until the next write.
- Throughput: one byte per cycle sustained. A byte may be accepted in the same cycle as the previous word's write pulse, so there are no bubbles.
- Last byte accepted at cycle T:
  - T+1: mem_wen_o=1 and state=DONE (rx_ready_o=0, done_o=1).
  - T+2: core_rst_o=0, so the core leaves reset only after the final write edge.
- start_i in DONE: core_rst_o=1 from the next cycle.
- Minimum load time for N words: 2 + 4N accepted bytes, plus 2 cycles to core release.

## Structure
- Shared package imem_pkg:
  - loader_state_e enum (IDLE, HDR, DATA, DONE, ERR).
  - HDR_BYTES = 2, BYTES_PER_WORD = 4.
  - IMEM_ADDR_W = 14, used as the ADDR_W default and by the instruction memory.
- Single module; no sub-module. The byte packer (2-bit index + 24-bit holding register) is kept inline.
- At top level, the loader's addr/wen is muxed with the fetch path's addr, selected by core_rst_o.

## Test plan
- Reset, then idle with rx_valid_i=1 -> rx_ready_o=0, core_rst_o=1, mem_wen_o=0, all flags 0.
- start_i; bytes 02 00 13 0F 10 01 93 00 50 00 back-to-back -> wen@addr0 data 0x01100F13, wen@addr1 data 0x00500093; done_o=1 with the 2nd write, core_rst_o=0 one cycle later.
- Same image with rx_valid_i dropped for 3 cycles between every byte -> identical writes and addresses, no extra wen.
- Header 00 00 -> err_o=1, no wen, core_rst_o=1. Header 01 40 (0x4001) -> err_o=1. Header 00 40 (0x4000) -> accepted, last write at addr 0x3FFF.
- rst asserted after 2 data bytes of word 0 -> IDLE immediately, no wen; start_i plus a fresh 1-word image writes addr0 with the new word only.
- start_i pulsed during DATA -> ignored, load completes normally. start_i in DONE -> core_rst_o=1 next cycle, state HDR.
